// File: rtl/uart_cmd_responder_pkg.sv
`default_nettype none
// ============================================================================
// uart_cmd_responder_pkg : command codes, operand addresses, FSM encodings
// Rev 1.0
// ============================================================================
package uart_cmd_responder_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_GET_ADDR  = 4'd1,
    ST_GET_WDATA = 4'd2,
    ST_GET_A     = 4'd3,
    ST_GET_B     = 4'd4,
    ST_GET_FUN   = 4'd5,
    ST_RF_WRITE  = 4'd6,
    ST_RF_READ   = 4'd7,
    ST_WAIT_RD   = 4'd8,
    ST_WR_A      = 4'd9,
    ST_WR_B      = 4'd10,
    ST_ALU_GO    = 4'd11,
    ST_WAIT_ALU  = 4'd12,
    ST_SEND      = 4'd13
  } rsp_state_t;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_SEND    = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_responder_if.sv
`default_nettype none
// ============================================================================
// uart_cmd_responder_if : RX/TX byte streams, register-file and ALU buses
// Rev 1.0
// ============================================================================
interface uart_cmd_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int ALU_W  = 16
) ();
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_error;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_busy;
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_wr_en;
  logic [DATA_W-1:0] rf_wr_data;
  logic              rf_rd_en;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_rd_valid;
  logic [3:0]        alu_fun;
  logic              alu_en;
  logic [ALU_W-1:0]  alu_out;
  logic              alu_valid;
  logic              frame_err;

  // responder side
  modport slave (
    input  rx_data, rx_valid, rx_error, tx_busy, rf_rd_data, rf_rd_valid,
           alu_out, alu_valid,
    output tx_data, tx_valid, rf_addr, rf_wr_en, rf_wr_data, rf_rd_en,
           alu_fun, alu_en, frame_err
  );

  // environment side (UART, register file, ALU)
  modport master (
    output rx_data, rx_valid, rx_error, tx_busy, rf_rd_data, rf_rd_valid,
           alu_out, alu_valid,
    input  tx_data, tx_valid, rf_addr, rf_wr_en, rf_wr_data, rf_rd_en,
           alu_fun, alu_en, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_responder_sender.sv
`default_nettype none
// ============================================================================
// uart_tx_byte_sender : sends 1 or 2 bytes (LSB first) over a busy handshake
// Rev 1.0
// ============================================================================
module uart_tx_byte_sender
  import uart_cmd_responder_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_two_bytes,
  input  logic [2*DATA_W-1:0] i_data,
  input  logic                i_tx_busy,
  output logic [DATA_W-1:0]   o_tx_data,
  output logic                o_tx_valid,
  output logic                o_done
);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_hi;
  logic              r_more;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= TX_IDLE;
      r_cur      <= '0;
      r_hi       <= '0;
      r_more     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        TX_IDLE: if (i_start) begin
          r_cur   <= i_data[DATA_W-1:0];
          r_hi    <= i_data[2*DATA_W-1:DATA_W];
          r_more  <= i_two_bytes;
          r_state <= TX_SEND;
        end
        TX_SEND: if (!i_tx_busy) begin
          r_tx_data  <= r_cur;
          r_tx_valid <= 1'b1;
          r_state    <= TX_WAIT_HI;
        end
        TX_WAIT_HI: if (i_tx_busy) r_state <= TX_WAIT_LO;
        TX_WAIT_LO: if (!i_tx_busy) begin
          // a full busy pulse has been seen, so the transmitter took the byte
          if (r_more) begin
            r_cur   <= r_hi;
            r_more  <= 1'b0;
            r_state <= TX_SEND;
          end else begin
            r_done  <= 1'b1;
            r_state <= TX_IDLE;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_done     = r_done;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// uart_cmd_responder : parses RX command frames, drives RF/ALU, sends replies
// Rev 1.0
// ============================================================================
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int ALU_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_cmd_responder_if.slave bus
);

  rsp_state_t        r_state;
  logic [7:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_fun;
  logic [ALU_W-1:0]  r_result;
  logic [ADDR_W-1:0] r_rf_addr;
  logic              r_rf_wr_en;
  logic [DATA_W-1:0] r_rf_wr_data;
  logic              r_rf_rd_en;
  logic [3:0]        r_alu_fun;
  logic              r_alu_en;
  logic              r_frame_err;
  logic              r_send_start;
  logic              r_send_two;

  logic              w_in_get;
  logic              w_rx_window;
  logic [DATA_W-1:0] w_tx_data;
  logic              w_tx_valid;
  logic              w_send_done;

  assign w_in_get    = r_state inside {ST_GET_ADDR, ST_GET_WDATA, ST_GET_A, ST_GET_B, ST_GET_FUN};
  assign w_rx_window = w_in_get || (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_fun        <= '0;
      r_result     <= '0;
      r_rf_addr    <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_wr_data <= '0;
      r_rf_rd_en   <= 1'b0;
      r_alu_fun    <= '0;
      r_alu_en     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_send_start <= 1'b0;
      r_send_two   <= 1'b0;
    end else begin
      r_rf_wr_en   <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_alu_en     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_send_start <= 1'b0;
      if (bus.rx_valid && bus.rx_error && w_rx_window) begin
        r_frame_err <= 1'b1;
        r_state     <= ST_IDLE;
      end else begin
        // bytes arriving while executing or replying are dropped
        if (bus.rx_valid && !w_rx_window) r_frame_err <= 1'b1;
        case (r_state)
          ST_IDLE: if (bus.rx_valid) begin
            case (bus.rx_data)
              CMD_WR, CMD_RD: begin r_cmd <= bus.rx_data; r_state <= ST_GET_ADDR; end
              CMD_ALU_OP:     begin r_cmd <= bus.rx_data; r_state <= ST_GET_A;    end
              CMD_ALU_NOP:    begin r_cmd <= bus.rx_data; r_state <= ST_GET_FUN;  end
              default: ;
            endcase
          end
          ST_GET_ADDR: if (bus.rx_valid) begin
            r_addr <= bus.rx_data[ADDR_W-1:0];
            if (r_cmd == CMD_WR) begin
              r_state <= ST_GET_WDATA;
            end else begin
              r_rf_addr  <= bus.rx_data[ADDR_W-1:0];
              r_rf_rd_en <= 1'b1;
              r_state    <= ST_RF_READ;
            end
          end
          ST_GET_WDATA: if (bus.rx_valid) begin
            r_rf_addr    <= r_addr;
            r_rf_wr_data <= bus.rx_data;
            r_rf_wr_en   <= 1'b1;
            r_state      <= ST_RF_WRITE;
          end
          ST_GET_A: if (bus.rx_valid) begin r_a <= bus.rx_data; r_state <= ST_GET_B;   end
          ST_GET_B: if (bus.rx_valid) begin r_b <= bus.rx_data; r_state <= ST_GET_FUN; end
          ST_GET_FUN: if (bus.rx_valid) begin
            r_fun <= bus.rx_data[3:0];
            if (r_cmd == CMD_ALU_OP) begin
              r_rf_addr    <= ADDR_W'(OPA_ADDR);
              r_rf_wr_data <= r_a;
              r_rf_wr_en   <= 1'b1;
              r_state      <= ST_WR_A;
            end else begin
              r_alu_fun <= bus.rx_data[3:0];
              r_alu_en  <= 1'b1;
              r_state   <= ST_ALU_GO;
            end
          end
          ST_RF_WRITE: r_state <= ST_IDLE;
          ST_RF_READ:  r_state <= ST_WAIT_RD;
          ST_WAIT_RD: if (bus.rf_rd_valid) begin
            r_result     <= {{(ALU_W-DATA_W){1'b0}}, bus.rf_rd_data};
            r_send_two   <= 1'b0;
            r_send_start <= 1'b1;
            r_state      <= ST_SEND;
          end
          ST_WR_A: begin
            r_rf_addr    <= ADDR_W'(OPB_ADDR);
            r_rf_wr_data <= r_b;
            r_rf_wr_en   <= 1'b1;
            r_state      <= ST_WR_B;
          end
          ST_WR_B: begin
            r_alu_fun <= r_fun;
            r_alu_en  <= 1'b1;
            r_state   <= ST_ALU_GO;
          end
          ST_ALU_GO: r_state <= ST_WAIT_ALU;
          ST_WAIT_ALU: if (bus.alu_valid) begin
            r_result     <= bus.alu_out;
            r_send_two   <= 1'b1;
            r_send_start <= 1'b1;
            r_state      <= ST_SEND;
          end
          ST_SEND: if (w_send_done) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  uart_tx_byte_sender #(.DATA_W(DATA_W)) u_sender (
    .clk         (clk),
    .rst         (rst),
    .i_start     (r_send_start),
    .i_two_bytes (r_send_two),
    .i_data      (r_result),
    .i_tx_busy   (bus.tx_busy),
    .o_tx_data   (w_tx_data),
    .o_tx_valid  (w_tx_valid),
    .o_done      (w_send_done)
  );

  assign bus.tx_data    = w_tx_data;
  assign bus.tx_valid   = w_tx_valid;
  assign bus.rf_addr    = r_rf_addr;
  assign bus.rf_wr_en   = r_rf_wr_en;
  assign bus.rf_wr_data = r_rf_wr_data;
  assign bus.rf_rd_en   = r_rf_rd_en;
  assign bus.alu_fun    = r_alu_fun;
  assign bus.alu_en     = r_alu_en;
  assign bus.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_responder : scoreboard bench with RF, ALU and UART TX models
// Rev 1.0
// ============================================================================
module tb_uart_cmd_responder;

  logic clk;
  logic rst;

  uart_cmd_responder_if #(.DATA_W(8), .ADDR_W(4), .ALU_W(16)) bus ();

  uart_cmd_responder #(.DATA_W(8), .ADDR_W(4), .ALU_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard queues, one per output event kind
  int wr_q[$];
  int rd_q[$];
  int alu_q[$];
  int tx_q[$];
  int err_pend = 0;

  logic [7:0] mem_model [16];
  logic [7:0] rf_mem    [16];

  int rd_cnt = 0, rd_addr = 0, rd_lat_cfg = 0;
  int alu_cnt = 0, alu_hold = 0;
  logic [3:0] alu_fun_l = '0;
  int tx_pre = 0, tx_hi = 0, busy_len_cfg = 0;
  int mon_ns;
  int exp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU behaviour of the environment, shared by the ALU model and the reference
  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return a * b;
      4'd3:    return {a, b};
      default: return {b, a ^ b};
    endcase
  endfunction

  // Monitor first, then environment models, in one block to avoid races
  always @(negedge clk) begin
    if (!rst) begin
      mon_ns = int'(bus.rf_wr_en) + int'(bus.rf_rd_en) + int'(bus.alu_en) + int'(bus.tx_valid);
      if (mon_ns != 0) check("strobe_exclusive", mon_ns, 1);
      if (bus.rf_wr_en) begin
        check("rf_wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          exp_v = wr_q.pop_front();
          check("rf_wr_addr_data", {bus.rf_addr, bus.rf_wr_data}, exp_v);
        end
      end
      if (bus.rf_rd_en) begin
        check("rf_rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          exp_v = rd_q.pop_front();
          check("rf_rd_addr", bus.rf_addr, exp_v);
        end
      end
      if (bus.alu_en) begin
        check("alu_en_expected", alu_q.size() != 0, 1);
        if (alu_q.size() != 0) begin
          exp_v = alu_q.pop_front();
          check("alu_fun", bus.alu_fun, exp_v);
        end
      end
      if (bus.tx_valid) begin
        check("tx_while_tx_idle", {bus.tx_busy, tx_pre != 0, tx_hi != 0}, 0);
        check("tx_expected", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) begin
          exp_v = tx_q.pop_front();
          check("tx_data", bus.tx_data, exp_v);
        end
      end
      if (bus.frame_err) begin
        check("frame_err_expected", err_pend > 0, 1);
        if (err_pend > 0) err_pend--;
      end
    end

    bus.rf_rd_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin bus.rf_rd_valid = 1'b1; bus.rf_rd_data = rf_mem[rd_addr]; end
    end
    if (bus.rf_wr_en) rf_mem[bus.rf_addr] = bus.rf_wr_data;
    if (bus.rf_rd_en) begin
      rd_addr = int'(bus.rf_addr);
      rd_cnt  = (rd_lat_cfg != 0) ? rd_lat_cfg : int'($urandom_range(1, 4));
    end

    bus.alu_valid = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin bus.alu_valid = 1'b1; bus.alu_out = alu_ref(alu_fun_l, rf_mem[0], rf_mem[1]); end
    end
    if (bus.alu_en) begin
      alu_fun_l = bus.alu_fun;
      alu_cnt   = (alu_hold != 0) ? 25 : int'($urandom_range(1, 5));
    end

    if (tx_pre > 0) begin
      tx_pre--;
      if (tx_pre == 0) begin
        bus.tx_busy = 1'b1;
        tx_hi = (busy_len_cfg != 0) ? busy_len_cfg : int'($urandom_range(3, 10));
      end
    end else if (tx_hi > 0) begin
      tx_hi--;
      if (tx_hi == 0) bus.tx_busy = 1'b0;
    end
    if (bus.tx_valid) tx_pre = int'($urandom_range(1, 2));
  end

  task automatic send_byte(input logic [7:0] b, input logic e);
    @(negedge clk);
    bus.rx_data = b; bus.rx_valid = 1'b1; bus.rx_error = e;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic frame_wr(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back(int'({a[3:0], d}));
    mem_model[a[3:0]] = d;
    send_byte(8'hAA, 1'b0); send_byte(a, 1'b0); send_byte(d, 1'b0);
  endtask

  task automatic frame_rd(input logic [7:0] a);
    rd_q.push_back(int'(a[3:0]));
    tx_q.push_back(int'(mem_model[a[3:0]]));
    send_byte(8'hBB, 1'b0); send_byte(a, 1'b0);
  endtask

  task automatic push_alu_resp(input logic [3:0] f);
    logic [15:0] r;
    r = alu_ref(f, mem_model[0], mem_model[1]);
    tx_q.push_back(int'(r[7:0]));
    tx_q.push_back(int'(r[15:8]));
  endtask

  task automatic frame_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f, input bit resp);
    wr_q.push_back(int'({4'd0, a}));
    wr_q.push_back(int'({4'd1, b}));
    mem_model[0] = a; mem_model[1] = b;
    alu_q.push_back(int'(f[3:0]));
    if (resp) push_alu_resp(f[3:0]);
    send_byte(8'hCC, 1'b0); send_byte(a, 1'b0); send_byte(b, 1'b0); send_byte(f, 1'b0);
  endtask

  task automatic frame_nop(input logic [7:0] f);
    alu_q.push_back(int'(f[3:0]));
    push_alu_resp(f[3:0]);
    send_byte(8'hDD, 1'b0); send_byte(f, 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0 || alu_q.size() != 0 || tx_q.size() != 0 ||
            err_pend != 0 || bus.tx_busy || tx_pre != 0) && n < 3000) begin
      @(posedge clk); n++;
    end
    check("drain_within_bound", n < 3000, 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {bus.tx_valid, bus.tx_data, bus.rf_addr, bus.rf_wr_en, bus.rf_wr_data,
                 bus.rf_rd_en, bus.alu_fun, bus.alu_en, bus.frame_err}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int n;
    int k;
    int cut;
    logic [7:0] codes [4];
    int lens [4];
    codes[0] = 8'hAA; codes[1] = 8'hBB; codes[2] = 8'hCC; codes[3] = 8'hDD;
    lens[0] = 3; lens[1] = 2; lens[2] = 4; lens[3] = 2;
    for (int i = 0; i < 16; i++) begin mem_model[i] = '0; rf_mem[i] = '0; end
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.tx_busy = 1'b0;
    bus.rf_rd_data = '0; bus.rf_rd_valid = 1'b0; bus.alu_out = '0; bus.alu_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // write, then read back with fixed latency and long busy
    frame_wr(8'h05, 8'h3C); wait_drain();
    frame_wr(8'h02, 8'h7E); wait_drain();
    rd_lat_cfg = 3; busy_len_cfg = 10;
    frame_rd(8'h02); wait_drain();
    rd_lat_cfg = 0; busy_len_cfg = 0;

    frame_alu(8'h10, 8'h20, 8'h00, 1'b1); wait_drain();

    // errored byte aborts a write frame
    err_pend++;
    send_byte(8'hAA, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h77, 1'b1);
    wait_drain();
    frame_rd(8'h05); wait_drain();

    // stray byte while the reply is in flight
    busy_len_cfg = 8;
    frame_alu(8'h9C, 8'h47, 8'h01, 1'b1);
    n = 0;
    while (!bus.tx_busy && n < 500) begin @(posedge clk); n++; end
    check("tx_busy_seen", n < 500, 1);
    err_pend++;
    send_byte(8'h55, 1'b0);
    wait_drain();
    busy_len_cfg = 0;

    // reset while waiting for the ALU; its late result must be ignored
    alu_hold = 1;
    frame_alu(8'h12, 8'h34, 8'h02, 1'b0);
    n = 0;
    while (alu_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    check("alu_en_seen", n < 500, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_frame_reset_outputs");
    rst = 1'b0;
    alu_hold = 0;
    repeat (30) @(negedge clk);
    check_outputs_zero("post_reset_idle_outputs");
    frame_nop(8'h01); wait_drain();

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1: frame_wr(8'($urandom), 8'($urandom));
        2, 3: frame_rd(8'($urandom));
        4, 5: frame_alu(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        6:    frame_nop(8'($urandom));
        7: begin
          b = 8'($urandom);
          while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
          send_byte(b, 1'b0);
        end
        8: begin
          k = $urandom_range(0, 3);
          cut = $urandom_range(0, lens[k] - 2);
          err_pend++;
          send_byte(codes[k], 1'b0);
          for (int j = 0; j < cut; j++) send_byte(8'($urandom), 1'b0);
          send_byte(8'($urandom), 1'b1);
        end
        default: begin
          err_pend++;
          send_byte(8'($urandom), 1'b1);
        end
      endcase
      wait_drain();
    end

    check("queues_empty_at_end", wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size() + err_pend, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
